// File: rtl/gate_eval_arbiter.sv
// Round-robin sequencer that shares one registered NAND-OR unit between NUM_REQ requesters.
// The winner's operands are latched onto the unit; after LAT edges its result is returned.
module gate_eval_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LAT     = 1,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] op_a,
    input  logic [NUM_REQ-1:0] op_b,
    input  logic [NUM_REQ-1:0] op_c,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_id,
    output logic [NUM_REQ-1:0] rsp_valid,
    output logic               rsp_data,
    output logic               busy,
    output logic               u_a,
    output logic               u_b,
    output logic               u_c,
    input  logic               u_q
);

    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]         state;
    logic [1:0]         state_d;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_d;
    logic [IDX_W-1:0]   win_id;
    logic [IDX_W-1:0]   cand;
    logic [NUM_REQ-1:0] win_oh;
    logic               win;
    logic               arb;
    logic [CNT_W-1:0]   cnt;

    // Search starts at ptr so the last winner ends up with lowest priority.
    always_comb begin
        win    = 1'b0;
        win_id = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = IDX_W'(idx);
            if (!win && req[cand]) begin
                win    = 1'b1;
                win_id = cand;
            end
        end
        win_oh = NUM_REQ'(1) << win_id;
        ptr_d  = (int'(win_id) == NUM_REQ - 1) ? '0 : win_id + IDX_W'(1);
    end

    assign arb = (state == IDLE) || (state == RESP);

    always_comb begin
        state_d = IDLE;
        case (state)
            IDLE:    state_d = win ? ISSUE : IDLE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = (cnt == '0) ? RESP : WAIT;
            RESP:    state_d = win ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            rsp_valid <= '0;
            rsp_data  <= 1'b0;
            busy      <= 1'b0;
            u_a       <= 1'b0;
            u_b       <= 1'b0;
            u_c       <= 1'b0;
        end else begin
            state     <= state_d;
            busy      <= (state_d != IDLE);
            gnt       <= '0;
            rsp_valid <= '0;
            if (arb && win) begin
                gnt    <= win_oh;
                gnt_id <= win_id;
                u_a    <= op_a[win_id];
                u_b    <= op_b[win_id];
                u_c    <= op_c[win_id];
                ptr    <= ptr_d;
            end
            if (state == ISSUE) begin
                cnt <= CNT_INIT;
            end
            // The unit sampled u_* at the end of ISSUE; u_q is valid once cnt reaches zero.
            if (state == WAIT) begin
                if (cnt == '0) begin
                    rsp_data  <= u_q;
                    rsp_valid <= NUM_REQ'(1) << gnt_id;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_eval_arbiter.sv
// Directed bench for gate_eval_arbiter: one LAT=1 and one LAT=3 instance, each with a model
// of the shared NAND-OR unit, an expected-grant queue and an expected-response queue.
module tb_gate_eval_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // LAT=1 instance signals
  logic [3:0] req1 = '0, a1 = '0, b1 = '0, c1 = '0;
  logic [3:0] gnt1, rv1;
  logic [1:0] id1;
  logic       rd1, busy1, ua1, ub1, uc1, uq1;
  // LAT=3 instance signals
  logic [3:0] req3 = '0, a3 = '0, b3 = '0, c3 = '0;
  logic [3:0] gnt3, rv3;
  logic [1:0] id3;
  logic       rd3, busy3, ua3, ub3, uc3, uq3;
  logic [2:0] pipe3;

  gate_eval_arbiter #(.NUM_REQ(4), .LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .op_a(a1), .op_b(b1), .op_c(c1),
    .gnt(gnt1), .gnt_id(id1), .rsp_valid(rv1), .rsp_data(rd1), .busy(busy1),
    .u_a(ua1), .u_b(ub1), .u_c(uc1), .u_q(uq1)
  );

  gate_eval_arbiter #(.NUM_REQ(4), .LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .op_a(a3), .op_b(b3), .op_c(c3),
    .gnt(gnt3), .gnt_id(id3), .rsp_valid(rv3), .rsp_data(rd3), .busy(busy3),
    .u_a(ua3), .u_b(ub3), .u_c(uc3), .u_q(uq3)
  );

  // Shared-unit models: 1-stage and 3-stage registered ~(a&b)|c.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) uq1 <= 1'b0;
    else        uq1 <= ~(ua1 & ub1) | uc1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe3 <= '0;
    else        pipe3 <= {pipe3[1:0], ~(ua3 & ub3) | uc3};
  end
  assign uq3 = pipe3[2];

  // Scoreboard queues: grant = {onehot, id}, response = {onehot, data}.
  logic [5:0] gnt_q1[$], gnt_q3[$];
  logic [4:0] rsp_q1[$], rsp_q3[$];
  int gcyc1 = 0, gcyc3 = 0;

  always @(negedge clk) begin
    logic [5:0] eg;
    logic [4:0] er;
    if (gnt1 != '0) begin
      gcyc1 = cyc;
      n_cmp++;
      if (gnt_q1.size() == 0) begin
        n_err++;
        $display("FAIL gnt1_unexpected got=%b id=%0d", gnt1, id1);
      end else begin
        eg = gnt_q1.pop_front();
        if ({gnt1, id1} !== eg) begin
          n_err++;
          $display("FAIL gnt1 got=%b/%0d exp=%b/%0d", gnt1, id1, eg[5:2], eg[1:0]);
        end
      end
    end
    if (rv1 != '0) begin
      n_cmp += 2;
      if (cyc - gcyc1 != 2) begin
        n_err++;
        $display("FAIL lat1 got=%0d exp=2", cyc - gcyc1);
      end
      if (rsp_q1.size() == 0) begin
        n_err++;
        $display("FAIL rsp1_unexpected got=%b d=%b", rv1, rd1);
      end else begin
        er = rsp_q1.pop_front();
        if ({rv1, rd1} !== er) begin
          n_err++;
          $display("FAIL rsp1 got=%b/%b exp=%b/%b", rv1, rd1, er[4:1], er[0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [5:0] eg;
    logic [4:0] er;
    if (gnt3 != '0) begin
      gcyc3 = cyc;
      n_cmp++;
      if (gnt_q3.size() == 0) begin
        n_err++;
        $display("FAIL gnt3_unexpected got=%b id=%0d", gnt3, id3);
      end else begin
        eg = gnt_q3.pop_front();
        if ({gnt3, id3} !== eg) begin
          n_err++;
          $display("FAIL gnt3 got=%b/%0d exp=%b/%0d", gnt3, id3, eg[5:2], eg[1:0]);
        end
      end
    end
    if (rv3 != '0) begin
      n_cmp += 2;
      if (cyc - gcyc3 != 4) begin
        n_err++;
        $display("FAIL lat3 got=%0d exp=4", cyc - gcyc3);
      end
      if (rsp_q3.size() == 0) begin
        n_err++;
        $display("FAIL rsp3_unexpected got=%b d=%b", rv3, rd3);
      end else begin
        er = rsp_q3.pop_front();
        if ({rv3, rd3} !== er) begin
          n_err++;
          $display("FAIL rsp3 got=%b/%b exp=%b/%b", rv3, rd3, er[4:1], er[0]);
        end
      end
    end
  end

  task automatic expect1(input int id, input logic d);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    gnt_q1.push_back({oh, 2'(id)});
    rsp_q1.push_back({oh, d});
  endtask

  task automatic check_zero(input string name, input logic [14:0] got);
    n_cmp++;
    if (got !== '0) begin
      n_err++;
      $display("FAIL %s outputs got=%b exp=0", name, got);
    end
  endtask

  // Drive req on dut1 until n grants seen (optionally checking spacing), then wait for idle.
  task automatic run1(input logic [3:0] r, input int n, input int space);
    int seen = 0, t = 0, last = -1;
    req1 = r;
    while (seen < n && t < 200) begin
      @(negedge clk);
      t++;
      if (gnt1 != '0) begin
        seen++;
        if (space > 0 && last >= 0) begin
          n_cmp++;
          if (cyc - last != space) begin
            n_err++;
            $display("FAIL gnt_spacing got=%0d exp=%0d", cyc - last, space);
          end
        end
        last = cyc;
      end
    end
    req1 = '0;
    if (seen < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL grant_timeout got=%0d exp=%0d", seen, n);
    end
    t = 0;
    while (busy1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy1) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout got=busy exp=idle");
    end
  endtask

  initial begin
    int t;
    #1;
    check_zero("reset1", {gnt1, rv1, busy1, ua1, ub1, uc1, id1, rd1});
    check_zero("reset3", {gnt3, rv3, busy3, ua3, ub3, uc3, id3, rd3});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester 2: ~(1&1)|0 = 0, ~(0&1)|0 = 1, ~(1&1)|1 = 1
    a1 = 4'b0100; b1 = 4'b0100; c1 = 4'b0000; expect1(2, 1'b0); run1(4'b0100, 1, 0);
    a1 = 4'b0000;                             expect1(2, 1'b1); run1(4'b0100, 1, 0);
    a1 = 4'b0100; c1 = 4'b0100;               expect1(2, 1'b1); run1(4'b0100, 1, 0);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All requesting: order 0,1,2,3,0 spaced 3 cycles; b=0101 gives results 0,1,0,1,0
    a1 = 4'b1111; b1 = 4'b0101; c1 = 4'b0000;
    expect1(0, 1'b0); expect1(1, 1'b1); expect1(2, 1'b0); expect1(3, 1'b1); expect1(0, 1'b0);
    run1(4'b1111, 5, 3);

    // Serve 1 alone (ptr -> 2), then 0011 wraps to 0 first, then 1
    a1 = 4'b0000; b1 = 4'b0000; c1 = 4'b0000; expect1(1, 1'b1); run1(4'b0010, 1, 0);
    a1 = 4'b0011; b1 = 4'b0011;               expect1(0, 1'b0); expect1(1, 1'b0);
    run1(4'b0011, 2, 0);

    // Reset while dut1 is in WAIT: no response, then ptr back to 0
    a1 = 4'b0001; b1 = 4'b0001; c1 = 4'b0001;
    gnt_q1.push_back({4'b0001, 2'd0});
    req1 = 4'b0001;
    t = 0;
    while (gnt1 == '0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    req1 = '0;
    n_cmp++;
    if (gnt1 != 4'b0001) begin
      n_err++;
      $display("FAIL rst_wait_grant got=%b exp=0001", gnt1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("reset_in_wait", {gnt1, rv1, busy1, ua1, ub1, uc1, id1, rd1});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a1 = 4'b1111; b1 = 4'b0000; c1 = 4'b0000; expect1(0, 1'b1); run1(4'b1111, 1, 0);

    // LAT=3: operands toggle the cycle after the grant; result uses latched a=b=1,c=0
    a3 = 4'b0010; b3 = 4'b0010; c3 = 4'b0000;
    gnt_q3.push_back({4'b0010, 2'd1});
    rsp_q3.push_back({4'b0010, 1'b0});
    req3 = 4'b0010;
    t = 0;
    while (gnt3 == '0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    req3 = '0;
    @(negedge clk);
    a3 = 4'b0000; c3 = 4'b1111;
    t = 0;
    while (rsp_q3.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);

    n_cmp += 4;
    if (gnt_q1.size() != 0) begin n_err++; $display("FAIL gnt_q1_left got=%0d exp=0", gnt_q1.size()); end
    if (rsp_q1.size() != 0) begin n_err++; $display("FAIL rsp_q1_left got=%0d exp=0", rsp_q1.size()); end
    if (gnt_q3.size() != 0) begin n_err++; $display("FAIL gnt_q3_left got=%0d exp=0", gnt_q3.size()); end
    if (rsp_q3.size() != 0) begin n_err++; $display("FAIL rsp_q3_left got=%0d exp=0", rsp_q3.size()); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
